// File: rtl/maxpool2x2_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool core: state encoding and
// a width helper used to size the window counters.
package maxpool2x2_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_ADDR   = 3'd1;
  localparam logic [ST_W-1:0] ST_SAMPLE = 3'd2;
  localparam logic [ST_W-1:0] ST_WRITE  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE   = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_ADDR   = ST_ADDR,
    S_SAMPLE = ST_SAMPLE,
    S_WRITE  = ST_WRITE,
    S_DONE   = ST_DONE
  } state_t;

  // Bits needed to count 0..depth-1; never less than one bit.
  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned bits;
    bits = 1;
    while ((32'd1 << bits) < depth) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/maxpool2x2_addr_gen.sv
// Window/element counters and buffer address generation for the max-pool core.
// The input address is registered and loaded from the post-step counter values.
module maxpool2x2_addr_gen
  import maxpool2x2_pkg::*;
#(
  parameter int unsigned IMG_W         = 4,
  parameter int unsigned IMG_H         = 4,
  parameter int unsigned IN_ADR_WIDTH  = 8,
  parameter int unsigned OUT_ADR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     step_elem,
  input  logic                     step_win,
  input  logic                     adr_load,
  input  logic                     adr_keep,
  output logic [IN_ADR_WIDTH-1:0]  in_adr,
  output logic [OUT_ADR_WIDTH-1:0] out_adr_c,
  output logic                     first_elem_c,
  output logic                     last_elem_c,
  output logic                     last_win_c
);

  localparam int unsigned OX_W = clogb2(IMG_W / 2);
  localparam int unsigned OY_W = clogb2(IMG_H / 2);
  localparam logic [OX_W-1:0] OX_LAST = OX_W'(IMG_W / 2 - 1);
  localparam logic [OY_W-1:0] OY_LAST = OY_W'(IMG_H / 2 - 1);

  logic [OX_W-1:0] ox, ox_nxt;
  logic [OY_W-1:0] oy, oy_nxt;
  logic            dx, dx_nxt;
  logic            dy, dy_nxt;
  logic [IN_ADR_WIDTH-1:0] in_adr_nxt;

  assign first_elem_c = !dx && !dy;
  assign last_elem_c  = dx && dy;
  assign last_win_c   = (ox == OX_LAST) && (oy == OY_LAST);

  assign out_adr_c = OUT_ADR_WIDTH'(32'(oy) * (IMG_W / 2) + 32'(ox));

  // Element order inside a window is dx-fastest; the 4th step wraps to (0,0).
  always_comb begin
    ox_nxt = ox;
    oy_nxt = oy;
    dx_nxt = dx;
    dy_nxt = dy;
    if (clear) begin
      ox_nxt = '0;
      oy_nxt = '0;
      dx_nxt = 1'b0;
      dy_nxt = 1'b0;
    end else begin
      if (step_elem) begin
        dx_nxt = !dx;
        dy_nxt = dy ^ dx;
      end
      if (step_win) begin
        if (ox == OX_LAST) begin
          ox_nxt = '0;
          oy_nxt = (oy == OY_LAST) ? '0 : oy + OY_W'(1);
        end else begin
          ox_nxt = ox + OX_W'(1);
        end
      end
    end
  end

  assign in_adr_nxt = IN_ADR_WIDTH'((32'(oy_nxt) * 2 + 32'(dy_nxt)) * IMG_W
                                    + 32'(ox_nxt) * 2 + 32'(dx_nxt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox     <= '0;
      oy     <= '0;
      dx     <= 1'b0;
      dy     <= 1'b0;
      in_adr <= '0;
    end else begin
      ox <= ox_nxt;
      oy <= oy_nxt;
      dx <= dx_nxt;
      dy <= dy_nxt;
      if (adr_load) begin
        in_adr <= in_adr_nxt;
      end else if (!adr_keep) begin
        in_adr <= '0;
      end
    end
  end

endmodule

// File: rtl/maxpool2x2_core.sv
// 2x2, stride-2 max pooling of a signed IMG_H x IMG_W image from the input
// buffer into the output buffer, started by a pulse and ending with a done pulse.
module maxpool2x2_core
  import maxpool2x2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IMG_W         = 4,
  parameter int unsigned IMG_H         = 4,
  parameter int unsigned IN_ADR_WIDTH  = 8,
  parameter int unsigned OUT_ADR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     axisif_start,
  output logic                     axisif_done,
  output logic [IN_ADR_WIDTH-1:0]  axisif_bufferIn_adr,
  input  logic [DATA_WIDTH-1:0]    axisif_bufferIn_data,
  output logic [OUT_ADR_WIDTH-1:0] axisif_bufferOut_adr,
  output logic [DATA_WIDTH-1:0]    axisif_bufferOut_data,
  output logic                     axisif_bufferOut_wr
);

  state_t                   state;
  logic [DATA_WIDTH-1:0]    acc;
  logic [DATA_WIDTH-1:0]    acc_nxt_c;
  logic [OUT_ADR_WIDTH-1:0] out_adr_c;
  logic                     first_elem_c;
  logic                     last_elem_c;
  logic                     last_win_c;
  logic                     clear_c;
  logic                     step_elem_c;
  logic                     step_win_c;
  logic                     adr_load_c;
  logic                     adr_keep_c;

  maxpool2x2_addr_gen #(
    .IMG_W         (IMG_W),
    .IMG_H         (IMG_H),
    .IN_ADR_WIDTH  (IN_ADR_WIDTH),
    .OUT_ADR_WIDTH (OUT_ADR_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear_c),
    .step_elem    (step_elem_c),
    .step_win     (step_win_c),
    .adr_load     (adr_load_c),
    .adr_keep     (adr_keep_c),
    .in_adr       (axisif_bufferIn_adr),
    .out_adr_c    (out_adr_c),
    .first_elem_c (first_elem_c),
    .last_elem_c  (last_elem_c),
    .last_win_c   (last_win_c)
  );

  // Counter/address strobes: address is (re)loaded on entry to ADDR, held
  // through SAMPLE, and zeroed whenever the next state is IDLE or DONE.
  always_comb begin
    clear_c     = 1'b0;
    step_elem_c = 1'b0;
    step_win_c  = 1'b0;
    adr_load_c  = 1'b0;
    adr_keep_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (axisif_start) begin
          clear_c    = 1'b1;
          adr_load_c = 1'b1;
        end
      end
      S_ADDR:   adr_keep_c = 1'b1;
      S_SAMPLE: begin
        step_elem_c = 1'b1;
        adr_keep_c  = last_elem_c;
        adr_load_c  = !last_elem_c;
      end
      S_WRITE: begin
        step_win_c = 1'b1;
        adr_load_c = !last_win_c;
      end
      default: ;
    endcase
  end

  // Signed running max; strict compare keeps the earlier value on ties.
  always_comb begin
    acc_nxt_c = acc;
    if (first_elem_c || ($signed(axisif_bufferIn_data) > $signed(acc))) begin
      acc_nxt_c = axisif_bufferIn_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= S_IDLE;
      acc                   <= '0;
      axisif_done           <= 1'b0;
      axisif_bufferOut_wr   <= 1'b0;
      axisif_bufferOut_adr  <= '0;
      axisif_bufferOut_data <= '0;
    end else begin
      axisif_done         <= 1'b0;
      axisif_bufferOut_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (axisif_start) state <= S_ADDR;
        end
        S_ADDR: state <= S_SAMPLE;
        S_SAMPLE: begin
          acc <= acc_nxt_c;
          if (last_elem_c) begin
            state                 <= S_WRITE;
            axisif_bufferOut_wr   <= 1'b1;
            axisif_bufferOut_adr  <= out_adr_c;
            axisif_bufferOut_data <= acc_nxt_c;
          end else begin
            state <= S_ADDR;
          end
        end
        S_WRITE: begin
          if (last_win_c) begin
            state       <= S_DONE;
            axisif_done <= 1'b1;
          end else begin
            state <= S_ADDR;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
